rv0_wbs: RTL
============

RV0_WBS -- requirements
Module: rv0_wbs

Interface
REQ-001 Parameter EXU_CNT, default 4, number of execution units competing for write-back (power of 2, >=2).
REQ-002 Parameter ROB_DEPTH, default 8, in-flight instruction slots (power of 2, >=2); TW = $clog2(ROB_DEPTH), EW = $clog2(EXU_CNT).
REQ-003 Parameter TIMEOUT, default 255, head-stall cycle limit (used only under RV0_WBS_TIMEOUT_EN).
REQ-004 clk_i  in  1  single core clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 flush_i  in  1  discard all in-flight entries (control transfer taken).
REQ-007 alloc_req_i  in  1  dispatch requests one slot.
REQ-008 alloc_gnt_o  out  1  slot granted this cycle.
REQ-009 alloc_tag_o  out  TW  tag of the granted slot (current tail).
REQ-010 cmpl_vld_i  in  EXU_CNT  EXU i holds a completed result.
REQ-011 cmpl_tag_i  in  EXU_CNT*TW  tag of EXU i result, slice [i*TW +: TW].
REQ-012 cmpl_ack_o  out  EXU_CNT  EXU i result consumed by write-back this cycle.
REQ-013 ret_vld_o  out  1  head result available for write-back.
REQ-014 ret_sel_o  out  EW  EXU index to mux into write-back stage.
REQ-015 ret_rdy_i  in  1  write-back stage accepts result.
REQ-016 occ_o  out  TW+1  registered occupancy count.
REQ-017 err_timeout_o  out  1  sticky head-stall error.

Function
REQ-018 State: head_q, tail_q (TW bits, wrap modulo ROB_DEPTH), occ_q (0..ROB_DEPTH); empty = occ_q==0, full = occ_q==ROB_DEPTH.
REQ-019 alloc_gnt_o = alloc_req_i & ~full & ~flush_i; alloc_tag_o = tail_q (combinational); tail_q increments on grant.
REQ-020 ret_vld_o = ~empty & ~flush_i & (some i has cmpl_vld_i[i] and tag_i == head_q); ret_sel_o = lowest such i, 0 when none.
REQ-021 Retire handshake: ret_vld_o & ret_rdy_i -> cmpl_ack_o[ret_sel_o]=1 same cycle, head_q increments next edge; all other cmpl_ack_o bits 0.
REQ-022 Completion whose tag != head_q is never acked; EXU holds it (no reordering out of program order).
REQ-023 occ_q next = occ_q + grant - retire; simultaneous grant and retire leaves occ_q unchanged (legal when full: retire frees, but grant uses registered full so no grant when full).
REQ-024 flush_i: no grant, no retire that cycle; next edge head_q=tail_q=0, occ_q=0; flush takes priority over all other events.
REQ-025 Latency: tag allocated at cycle N is retirable at cycle N+1 at earliest; one retire per cycle maximum.
REQ-026 Pointer wrap: tag ROB_DEPTH-1 followed by tag 0 with no bubble.
REQ-027 occ_o = occ_q.

Reset
REQ-028 rst_i high at edge: head_q=0, tail_q=0, occ_q=0, timeout counter=0, error flag=0; overrides flush_i and all requests.
REQ-029 During and after reset until first grant: alloc_gnt_o follows alloc_req_i, ret_vld_o=0, cmpl_ack_o=0, occ_o=0, err_timeout_o=0, ret_sel_o=0.
REQ-030 Reset mid-operation discards all in-flight tags; EXUs are reset by the same rst_i.

Configuration
REQ-031 Macro RV0_WBS_TIMEOUT_EN defined: counter increments each cycle ~empty & no retire, clears on retire, flush or empty; reaching TIMEOUT sets err_timeout_o, held until rst_i or flush_i.
REQ-032 Macro undefined: no counter logic, err_timeout_o tied 0; all other behaviour identical.

Verification
REQ-033 Reset, alloc_req_i=1 for 8 cycles, no completions -> tags 0..7 granted, occ_o=8, 9th request alloc_gnt_o=0.
REQ-034 Tags 0,1 allocated; EXU2 completes tag 1, EXU0 later completes tag 0, ret_rdy_i=1 -> ack EXU0 first (ret_sel_o=0), then EXU2 (ret_sel_o=2) next cycle.
REQ-035 Full (occ 8), same cycle alloc_req_i=1 and retire of head -> no grant, occ_o=7; next cycle grant with tag = old head.
REQ-036 occ 5, EXU1 holding head tag, flush_i=1 with ret_rdy_i=1 -> cmpl_ack_o=0, next cycle occ_o=0, alloc_tag_o=0.
REQ-037 RV0_WBS_TIMEOUT_EN, TIMEOUT=4, one tag allocated, never completed -> err_timeout_o=1 after 4 stall cycles, stays 1 until flush_i.
REQ-038 Allocate/retire 20 tags back-to-back with ROB_DEPTH=8 -> tags wrap 7->0, no bubble, occ_o constant 1.

Source files
------------

// File: rtl/rv0_wbs_if.sv
// rv0_wbs_if: dispatch, completion and write-back signals of the write-back sequencer
interface rv0_wbs_if #(
  parameter int EXU_CNT = 4,
  parameter int ROB_DEPTH = 8
);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int EW = $clog2(EXU_CNT);
  logic flush_i;
  logic alloc_req_i;
  logic alloc_gnt_o;
  logic [TW-1:0] alloc_tag_o;
  logic [EXU_CNT-1:0] cmpl_vld_i;
  logic [EXU_CNT*TW-1:0] cmpl_tag_i;
  logic [EXU_CNT-1:0] cmpl_ack_o;
  logic ret_vld_o;
  logic [EW-1:0] ret_sel_o;
  logic ret_rdy_i;
  logic [TW:0] occ_o;
  logic err_timeout_o;
  modport slave(
    input flush_i, alloc_req_i, cmpl_vld_i, cmpl_tag_i, ret_rdy_i,
    output alloc_gnt_o, alloc_tag_o, cmpl_ack_o, ret_vld_o, ret_sel_o, occ_o, err_timeout_o
  );
  modport master(
    output flush_i, alloc_req_i, cmpl_vld_i, cmpl_tag_i, ret_rdy_i,
    input alloc_gnt_o, alloc_tag_o, cmpl_ack_o, ret_vld_o, ret_sel_o, occ_o, err_timeout_o
  );
endinterface

// File: rtl/rv0_wbs.sv
// rv0_wbs: in-order write-back sequencer retiring EXU results by tag; RV0_WBS_TIMEOUT_EN adds a head-stall error
module rv0_wbs #(
  parameter int EXU_CNT = 4,
  parameter int ROB_DEPTH = 8,
  parameter int TIMEOUT = 255
) (
  input logic clk_i,
  input logic rst_i,
  rv0_wbs_if.slave bus
);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int EW = $clog2(EXU_CNT);
  logic [TW-1:0] head_q, tail_q;
  logic [TW:0] occ_q;
  logic empty, full, grant, hit, retire;
  logic [EW-1:0] sel;
  assign empty = occ_q == '0;
  assign full = occ_q == (TW+1)'(ROB_DEPTH);
  assign grant = bus.alloc_req_i & ~full & ~bus.flush_i;
  // descending scan so the lowest matching EXU wins
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = EXU_CNT - 1; i >= 0; i--)
      if (bus.cmpl_vld_i[i] && bus.cmpl_tag_i[i*TW +: TW] == head_q) begin
        hit = 1'b1;
        sel = EW'(i);
      end
  end
  assign retire = bus.ret_vld_o & bus.ret_rdy_i;
  assign bus.alloc_gnt_o = grant;
  assign bus.alloc_tag_o = tail_q;
  assign bus.ret_vld_o = ~empty & ~bus.flush_i & hit;
  assign bus.ret_sel_o = sel;
  assign bus.cmpl_ack_o = EXU_CNT'(retire) << sel;
  assign bus.occ_o = occ_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q <= '0;
    end else begin
      head_q <= head_q + TW'(retire);
      tail_q <= tail_q + TW'(grant);
      occ_q <= occ_q + (TW+1)'(grant) - (TW+1)'(retire);
    end
  end
`ifdef RV0_WBS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic err_q;
  assign bus.err_timeout_o = err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (empty || retire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
      err_q <= err_q | (cnt_q >= CW'(TIMEOUT - 1));
    end
  end
`else
  assign bus.err_timeout_o = TIMEOUT < 0;
`endif
endmodule
